// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   port_id_t   : which core port owns the current transaction
//   word_byte() : pick byte lane of a little-endian 32-bit word
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_id_t;

    // Read needs one extra beat to capture the byte addressed at cnt=3.
    localparam logic [2:0] READ_LAST_CNT  = 3'd4;
    localparam logic [2:0] WRITE_LAST_CNT = 3'd3;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_byte_serdes.sv
// Byte serialiser/deserialiser between the 32-bit core ports and the
// byte-wide RAM.
//   clk, rst   : clock, async active-low reset
//   advance    : increment beat counter this cycle, otherwise it returns to 0
//   capture    : store rdata into lane cnt-1 of the assembly register
//   wdata, sel : latched store word and byte enables
//   rdata      : RAM read byte
//   cnt        : current beat (0..4)
//   wbyte, wen : write byte and its enable for lane cnt
//   word_next  : assembly register including this cycle's captured byte
module mem_byte_serdes
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        capture,
    input  logic [31:0] wdata,
    input  logic [3:0]  sel,
    input  logic [7:0]  rdata,
    output logic [2:0]  cnt,
    output logic [7:0]  wbyte,
    output logic        wen,
    output logic [31:0] word_next
);

    logic [2:0]  cnt_q;
    logic [31:0] word_q;
    logic [1:0]  lane;
    logic [1:0]  cap_lane;

    assign lane     = cnt_q[1:0];
    // cnt=4 wraps to lane 3, so the last beat lands in the top byte.
    assign cap_lane = cnt_q[1:0] - 2'd1;

    always_comb begin
        word_next = word_q;
        if (capture) begin
            word_next[{cap_lane, 3'b000} +: 8] = rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 3'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= advance ? cnt_q + 3'd1 : 3'd0;
            word_q <= word_next;
        end
    end

    assign cnt   = cnt_q;
    assign wbyte = word_byte(wdata, lane);
    assign wen   = sel[lane];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's instruction-fetch and data ports onto one byte-wide
// single-port synchronous RAM, moving each 32-bit word as four byte beats.
//   clk, rst                          : clock, async active-low reset
//   if_ce/if_addr                     : fetch request
//   if_inst/if_valid/if_busy          : fetch result, completion pulse, stall
//   d_ce/d_we/d_addr/d_sel/d_wdata    : data request
//   d_rdata/d_valid/d_busy            : load result, completion pulse, stall
//   ram_addr/ram_we/ram_wdata/ram_rdata : external RAM (1-cycle read latency)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no transaction; arbitrate and latch the winning request
// ARB_READ  | beats 0..3 drive addresses, beats 1..4 capture returned bytes
// ARB_WRITE | beats 0..3 drive address/byte, strobe where sel is set
// ARB_DONE  | owner's valid is high for this single cycle
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 17,
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    output logic              if_busy,
    input  logic              d_ce,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_sel,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    arb_state_t        state_q, state_d;
    port_id_t          owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       if_inst_q, d_rdata_q;
    logic              if_valid_q, d_valid_q;

    logic              grant_data, grant_inst;
    logic [ADDR_W-1:0] if_base, d_base, beat_addr;

    logic              advance, capture, wen;
    logic [2:0]        cnt;
    logic [7:0]        wbyte;
    logic [31:0]       word_next;

    logic              read_last, write_last;
    logic              unused_addr_bits;

    // Only the low ADDR_W bits address the RAM; alignment bits are dropped.
    assign unused_addr_bits = ^{if_addr, d_addr};
    assign if_base = {if_addr[ADDR_W-1:2], 2'b00};
    assign d_base  = {d_addr[ADDR_W-1:2], 2'b00};

    assign grant_data = d_ce && (DATA_PRIORITY || !if_ce);
    assign grant_inst = if_ce && !grant_data;

    assign read_last  = (state_q == ARB_READ)  && (cnt == READ_LAST_CNT);
    assign write_last = (state_q == ARB_WRITE) && (cnt == WRITE_LAST_CNT);
    assign advance    = ((state_q == ARB_READ) || (state_q == ARB_WRITE))
                        && !read_last && !write_last;
    assign capture    = (state_q == ARB_READ) && (cnt != 3'd0);

    mem_byte_serdes u_serdes (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .capture   (capture),
        .wdata     (wdata_q),
        .sel       (sel_q),
        .rdata     (ram_rdata),
        .cnt       (cnt),
        .wbyte     (wbyte),
        .wen       (wen),
        .word_next (word_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= PORT_INST;
            base_q  <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_data) begin
                    owner_d = PORT_DATA;
                    base_d  = d_base;
                    sel_d   = d_sel;
                    wdata_d = d_wdata;
                    state_d = d_we ? ARB_WRITE : ARB_READ;
                end else if (grant_inst) begin
                    owner_d = PORT_INST;
                    base_d  = if_base;
                    sel_d   = 4'hF;
                    wdata_d = 32'd0;
                    state_d = ARB_READ;
                end
            end
            ARB_READ:  if (read_last)  state_d = ARB_DONE;
            ARB_WRITE: if (write_last) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Beat address wraps within the RAM address space.
    assign beat_addr = base_q + ADDR_W'(cnt);

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (state_q == ARB_WRITE) begin
            ram_addr  = beat_addr;
            ram_we    = wen;
            ram_wdata = wbyte;
        end else if ((state_q == ARB_READ) && (cnt != READ_LAST_CNT)) begin
            ram_addr = beat_addr;
        end
    end

    // Results and valids are registered on the edge that enters DONE, so
    // they are already stable for the whole DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_inst_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if (read_last) begin
                if (owner_q == PORT_DATA) begin
                    d_valid_q <= 1'b1;
                    d_rdata_q <= word_next;
                end else begin
                    if_valid_q <= 1'b1;
                    if_inst_q  <= word_next;
                end
            end
            if (write_last) begin
                d_valid_q <= 1'b1;
            end
        end
    end

    assign if_inst  = if_inst_q;
    assign d_rdata  = d_rdata_q;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;

    // Gated by rst so the stall requests read 0 while in reset.
    assign if_busy = rst && if_ce && !if_valid_q;
    assign d_busy  = rst && d_ce && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 17;
    localparam int unsigned AMASK = (32'd1 << ADDR_W) - 1;
    localparam int RAM_WORDS = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              if_ce;
    logic [31:0]       if_addr;
    logic [31:0]       if_inst;
    logic              if_valid;
    logic              if_busy;
    logic              d_ce;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [3:0]        d_sel;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_valid;
    logic              d_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_PRIORITY(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_ce     (if_ce),
        .if_addr   (if_addr),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .if_busy   (if_busy),
        .d_ce      (d_ce),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_sel     (d_sel),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_busy    (d_busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // ---------------- external RAM model (synchronous, 1-cycle read) --------
    bit [7:0] ram_data    [0:RAM_WORDS-1];
    bit       ram_written [0:RAM_WORDS-1];
    int       wr_cnt = 0;
    logic [ADDR_W-1:0] wr_a [0:1023];
    logic [7:0]        wr_d [0:1023];

    function automatic bit [7:0] init_byte(input int unsigned a);
        return 8'((a * 32'd73) ^ (a >> 5) ^ 32'h5A);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            ram_data[ram_addr]    <= ram_wdata;
            ram_written[ram_addr] <= 1'b1;
            wr_a[wr_cnt % 1024]   <= ram_addr;
            wr_d[wr_cnt % 1024]   <= ram_wdata;
            wr_cnt                <= wr_cnt + 1;
        end
        ram_rdata <= ram_written[ram_addr] ? ram_data[ram_addr] : init_byte(32'(ram_addr));
    end

    // ---------------- reference model: byte memory + word rules -------------
    bit [7:0] ref_mem [int unsigned];
    logic [31:0] exp_if_inst = 32'd0;
    logic [31:0] exp_d_rdata = 32'd0;
    logic [ADDR_W-1:0] addr_seen [0:7];
    int last_wr_start = 0;

    function automatic bit [7:0] ref_byte(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int unsigned word_base(input logic [31:0] addr);
        return (addr & AMASK) & ~32'd3;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        logic [31:0] w;
        int unsigned b;
        b = word_base(addr);
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = ref_byte((b + i) & AMASK);
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, " ram_we"}, 32'(ram_we), 32'd0);
        check({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, " if_inst"}, if_inst, 32'd0);
        check({tag, " if_valid"}, 32'(if_valid), 32'd0);
        check({tag, " d_rdata"}, d_rdata, 32'd0);
        check({tag, " d_valid"}, 32'(d_valid), 32'd0);
        check({tag, " if_busy"}, 32'(if_busy), 32'd0);
        check({tag, " d_busy"}, 32'(d_busy), 32'd0);
    endtask

    // One request on one port, run to completion and checked against the model.
    // Latency counts clock edges from the drive point (IDLE cycle) to the
    // cycle where valid is seen: reads 6, stores 5.
    task automatic run_single(input string tag, input bit is_data, input bit we,
                              input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wdata);
        int n;
        int exp_lat;
        int k;
        int unsigned b;
        int nwr;
        bit seen;
        bit busy_ok;
        bit other_ok;
        logic [31:0] other_before;
        n = 0; seen = 0; busy_ok = 1; other_ok = 1;
        exp_lat = (is_data && we) ? 5 : 6;
        @(negedge clk);
        last_wr_start = wr_cnt;
        other_before = is_data ? if_inst : d_rdata;
        if (is_data) begin
            d_ce = 1'b1; d_we = we; d_addr = addr; d_sel = sel; d_wdata = wdata;
        end else begin
            if_ce = 1'b1; if_addr = addr;
        end
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n < 8) addr_seen[n] = ram_addr;
            if (is_data ? d_valid : if_valid) seen = 1;
            else if (!(is_data ? d_busy : if_busy)) busy_ok = 0;
            if (is_data ? if_valid : d_valid) other_ok = 0;
            // Request fields are latched at acceptance; changing them must not matter.
            if (n == 1) begin
                if (is_data) begin
                    d_addr = $urandom; d_sel = 4'($urandom); d_wdata = $urandom;
                end else begin
                    if_addr = $urandom;
                end
            end
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy before valid"}, 32'(busy_ok), 32'd1);
        check({tag, " busy at valid"}, 32'(is_data ? d_busy : if_busy), 32'd0);
        check({tag, " other port quiet"}, 32'(other_ok), 32'd1);
        if (is_data) d_ce = 1'b0; else if_ce = 1'b0;
        b = word_base(addr);
        nwr = 0;
        if (is_data && we) begin
            for (int i = 0; i < 4; i++) if (sel[i]) begin
                ref_mem[(b + i) & AMASK] = wdata[i*8 +: 8];
                nwr++;
            end
            check({tag, " write count"}, wr_cnt - last_wr_start, nwr);
            k = last_wr_start;
            for (int i = 0; i < 4; i++) if (sel[i]) begin
                check({tag, " write addr"}, 32'(wr_a[k % 1024]), (b + i) & AMASK);
                check({tag, " write data"}, 32'(wr_d[k % 1024]), 32'(wdata[i*8 +: 8]));
                k++;
            end
            check({tag, " d_rdata held"}, d_rdata, exp_d_rdata);
        end else begin
            check({tag, " no writes"}, wr_cnt - last_wr_start, 0);
            if (is_data) begin
                exp_d_rdata = ref_read(addr);
                check({tag, " d_rdata"}, d_rdata, exp_d_rdata);
            end else begin
                exp_if_inst = ref_read(addr);
                check({tag, " if_inst"}, if_inst, exp_if_inst);
            end
        end
        check({tag, " other result held"}, is_data ? if_inst : d_rdata, other_before);
    endtask

    initial begin
        int n;
        int dn;
        int inn;
        bit if_busy_ok;
        bit no_pulse;
        bit is_data;
        bit we;
        logic [31:0] a;

        rst = 1'b0;
        if_ce = 1'b0; if_addr = 32'd0;
        d_ce = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_sel = 4'd0; d_wdata = 32'd0;
        #1;
        check_all_zero("reset");
        // Stall requests stay low while in reset even with ce asserted.
        if_ce = 1'b1; d_ce = 1'b1;
        #1;
        check_all_zero("reset with ce");
        if_ce = 1'b0; d_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Place a known instruction at 0 through the data port, then fetch it.
        run_single("store word0", 1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'h0010_0513);
        run_single("fetch word0", 1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'd0);
        check("fetch known inst", if_inst, 32'h0010_0513);

        // Partial store: only lanes 1 and 2 written.
        run_single("store sel0110", 1'b1, 1'b1, 32'h0000_0100, 4'b0110, 32'hAABB_CCDD);
        check("sel0110 first addr", 32'(wr_a[last_wr_start % 1024]), 32'h101);
        check("sel0110 first data", 32'(wr_d[last_wr_start % 1024]), 32'hCC);
        check("sel0110 second addr", 32'(wr_a[(last_wr_start + 1) % 1024]), 32'h102);
        check("sel0110 second data", 32'(wr_d[(last_wr_start + 1) % 1024]), 32'hBB);

        // Simultaneous load and fetch: data wins, fetch accepted in the IDLE
        // cycle after the load's DONE.
        @(negedge clk);
        d_ce = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_sel = 4'hF;
        if_ce = 1'b1; if_addr = 32'h0;
        n = 0; dn = 0; inn = 0; if_busy_ok = 1;
        while ((dn == 0 || inn == 0) && n < 40) begin
            @(negedge clk);
            n++;
            if (d_valid && dn == 0) begin dn = n; d_ce = 1'b0; end
            if (if_valid && inn == 0) begin inn = n; if_ce = 1'b0; end
            else if (inn == 0 && !if_busy) if_busy_ok = 0;
        end
        d_ce = 1'b0; if_ce = 1'b0;
        check("simul d_valid time", dn, 6);
        check("simul if_valid time", inn, 13);
        check("simul if_busy held", 32'(if_busy_ok), 32'd1);
        exp_d_rdata = ref_read(32'h200);
        exp_if_inst = ref_read(32'h0);
        check("simul d_rdata", d_rdata, exp_d_rdata);
        check("simul if_inst", if_inst, exp_if_inst);

        // Top-of-memory word: beats must stay inside 0x1FFFC..0x1FFFF.
        run_single("wrap load", 1'b1, 1'b0, 32'h0001_FFFC, 4'hF, 32'd0);
        for (int i = 0; i < 4; i++)
            check("wrap beat addr", 32'(addr_seen[i+1]), 32'h1FFFC + i);

        // Upper address bits are discarded.
        run_single("trunc store", 1'b1, 1'b1, 32'hFFFE_0010, 4'b1001, $urandom);
        run_single("trunc load", 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);

        // Empty byte mask: completes on the store timing, touches nothing.
        run_single("store sel0000", 1'b1, 1'b1, 32'h0000_0300, 4'b0000, 32'h1234_5678);

        // Reset during beat cnt=2 of a fetch.
        @(negedge clk);
        if_ce = 1'b1; if_addr = 32'h40;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("mid-read reset");
        if_ce = 1'b0;
        no_pulse = 1;
        repeat (3) begin
            @(negedge clk);
            if (if_valid || d_valid) no_pulse = 0;
        end
        check("mid-read reset no pulse", 32'(no_pulse), 32'd1);
        rst = 1'b1;
        exp_if_inst = 32'd0;
        exp_d_rdata = 32'd0;
        run_single("fetch after reset", 1'b0, 1'b0, 32'h40, 4'h0, 32'd0);

        // Randomised traffic over a small window so loads hit earlier stores.
        for (int t = 0; t < 30; t++) begin
            is_data = 1'($urandom_range(0, 1));
            we = is_data && 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 7)) << 2);
            run_single(is_data ? (we ? "rand store" : "rand load") : "rand fetch",
                       is_data, we, a, 4'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
